// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter.
//   - arb_state_e : arbiter FSM states
//   - Def*        : default widths / streak limit
//   - streak_width: counter width able to hold 0..max_streak
package imem_arb_pkg;

  localparam int unsigned DefAddrW         = 32;
  localparam int unsigned DefDataW         = 32;
  localparam int unsigned DefMaxLoadStreak = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StLoad  = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  // Never return 0 so a streak limit of 0 still yields a legal vector.
  function automatic int unsigned streak_width(input int unsigned max_streak);
    int unsigned w;
    w = $clog2(max_streak + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the IF stage, the program loader, the arbiter and the
// instruction memory.
//   fetch_* : IF stage read requester (req/addr/flush in, valid/inst/freeze out)
//   load_*  : loader write requester (req/addr/data in, ack out)
//   mem_*   : single-port memory (req/we/addr/wdata out, rdata/ready in)
// Modports: master = arbiter side, slave = requesters + memory side.
interface imem_arbiter_if
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_flush;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_inst;
  logic              fetch_freeze;

  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  fetch_req, fetch_addr, fetch_flush,
    input  load_req, load_addr, load_data,
    input  mem_rdata, mem_ready,
    output fetch_valid, fetch_inst, fetch_freeze,
    output load_ack,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output fetch_req, fetch_addr, fetch_flush,
    output load_req, load_addr, load_data,
    output mem_rdata, mem_ready,
    input  fetch_valid, fetch_inst, fetch_freeze,
    input  load_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_arb_streak_cnt.sv
// Saturating counter of consecutive loader grants made while a fetch waits.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one more loader grant (saturates at MAX_COUNT)
//   clr      : restart the streak (wins over inc)
//   at_max   : streak has reached MAX_COUNT
module imem_arb_streak_cnt
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX_COUNT = DefMaxLoadStreak
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CntW = streak_width(MAX_COUNT);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == CntW'(MAX_COUNT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Sequencer for the shared single-port instruction memory. Arbitrates between
// IF-stage fetches and loader writes, holds each access until mem_ready, and
// drains a flushed fetch without withdrawing the memory request.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : imem_arbiter_if master view (fetch_*, load_*, mem_* groups)
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = DefAddrW,
  parameter int unsigned DATA_W          = DefDataW,
  parameter int unsigned MAX_LOAD_STREAK = DefMaxLoadStreak
) (
  input logic            clk,
  input logic            rst,
  imem_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;

  logic grant_fetch;
  logic grant_load;
  logic streak_at_max;
  logic streak_inc;
  logic streak_clr;

  // Streak only grows while a fetch is actually being held off.
  assign streak_inc = grant_load & bus.fetch_req;
  assign streak_clr = grant_fetch | (grant_load & ~bus.fetch_req);

  imem_arb_streak_cnt #(
    .MAX_COUNT (MAX_LOAD_STREAK)
  ) u_streak (
    .clk    (clk),
    .rst    (rst),
    .inc    (streak_inc),
    .clr    (streak_clr),
    .at_max (streak_at_max)
  );

  always_comb begin
    state_d     = state_q;
    grant_fetch = 1'b0;
    grant_load  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Loader has priority until it has starved a pending fetch long enough.
        if (bus.load_req && !(bus.fetch_req && streak_at_max)) begin
          grant_load = 1'b1;
          state_d    = StLoad;
        end else if (bus.fetch_req) begin
          grant_fetch = 1'b1;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        if (bus.mem_ready) begin
          state_d = StIdle;
        end else if (bus.fetch_flush) begin
          state_d = StDrain;
        end
      end
      StLoad: begin
        if (bus.mem_ready) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (bus.mem_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_load) begin
        addr_q <= bus.load_addr;
        data_q <= bus.load_data;
        we_q   <= 1'b1;
      end else if (grant_fetch) begin
        addr_q <= bus.fetch_addr;
        we_q   <= 1'b0;
      end
    end
  end

  // Memory side depends on registered state only.
  assign bus.mem_req   = (state_q != StIdle);
  assign bus.mem_we    = bus.mem_req & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = data_q;

  // Completion pulses are masked during reset so an aborted access never reports.
  assign bus.fetch_valid  = ~rst & (state_q == StFetch) & bus.mem_ready & ~bus.fetch_flush;
  assign bus.fetch_inst   = bus.fetch_valid ? bus.mem_rdata : '0;
  assign bus.fetch_freeze = bus.fetch_req & ~bus.fetch_valid;
  assign bus.load_ack     = ~rst & (state_q == StLoad) & bus.mem_ready;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequencing controller for the shared single-port instruction memory behind the IF stage. It arbitrates between the fetch path (reads at the PC) and the program loader (writes that fill instruction memory before or between runs). It holds each access stable until the memory acknowledges it, and it cancels in-flight fetches on a branch flush. It produces the fetch-side freeze that stalls the PC register while an instruction is not yet available.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, instruction/data width
- MAX_LOAD_STREAK, 4, consecutive loader grants allowed while a fetch is pending

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  IF stage requests the instruction at fetch_addr
- fetch_addr  in  ADDR_W  PC to read
- fetch_flush  in  1  branch taken; cancels the current fetch
- fetch_valid  out  1  fetch_inst valid this cycle (1-cycle pulse)
- fetch_inst  out  DATA_W  instruction read
- fetch_freeze  out  1  fetch_req & ~fetch_valid
- load_req  in  1  loader write request
- load_addr  in  ADDR_W  write address
- load_data  in  DATA_W  write data
- load_ack  out  1  write completed (1-cycle pulse)
- mem_req  out  1  memory access active
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- mem_ready  in  1  access complete this cycle

## Operation
- FSM states: IDLE, FETCH, LOAD, DRAIN.
- IDLE, arbitration:
  - Only one requester pending: grant it.
  - Both pending: grant LOAD, unless load_streak == MAX_LOAD_STREAK; then grant FETCH.
  - On a grant, latch addr, data and we into registers and go to FETCH or LOAD.
  - fetch_flush in IDLE has no effect.
- FETCH: mem_req=1, mem_we=0, mem_addr = latched PC.
  - On mem_ready without flush: fetch_valid=1, fetch_inst=mem_rdata (same cycle), then IDLE.
  - fetch_flush without mem_ready: go to DRAIN.
  - fetch_flush together with mem_ready: fetch_valid stays 0, go to IDLE.
- DRAIN: mem_req stays 1 with the same address and is never withdrawn mid-access. On mem_ready, data is discarded, fetch_valid stays 0, go to IDLE.
- LOAD: mem_req=1, mem_we=1, latched addr/data. On mem_ready: load_ack=1, then IDLE. fetch_flush is ignored.
- load_streak (saturating, width clog2(MAX_LOAD_STREAK+1)):
  - +1 on a LOAD grant while fetch_req=1.
  - Cleared on a FETCH grant, and on a LOAD grant with fetch_req=0.
- Requesters keep req/addr/data stable until fetch_valid or load_ack. A changed fetch_addr after the grant is not observed.
- mem_ready in IDLE is ignored.

## Timing
- Reset values: state=IDLE, load_streak=0. mem_req, mem_we, fetch_valid, load_ack = 0. mem_addr, mem_wdata, fetch_inst = 0. fetch_freeze = fetch_req.
- Minimum access is 2 cycles: request seen in IDLE in cycle N, mem_req high in N+1, completion in N+1 if mem_ready=1 there.
- Memory wait states extend FETCH/LOAD/DRAIN indefinitely with outputs held.
- Back-to-back accesses always pass through one IDLE cycle.
- Reset mid-access: IDLE next cycle, mem_req low, no valid/ack for the aborted access.
- mem_* outputs are registered or decoded from registered state only; no combinational path from fetch_req/load_req to mem_req.

## Structure
- Package imem_arb_pkg: state enum (IDLE, FETCH, LOAD, DRAIN) and the default ADDR_W/DATA_W constants.
- Sub-module imem_arb_streak_cnt: saturating streak counter with inc/clr inputs and an at_max output.
- Arbitration and FSM stay in the top.

## Test plan
- Fetch only, addr 5, mem_ready one cycle after mem_req: mem_req rises cycle 1; fetch_valid + inst pulse in cycle 2; freeze high cycles 0-1.
- Fetch 7, flush in the cycle after the grant, mem_ready 3 cycles later: DRAIN with mem_addr held at 7, no fetch_valid, IDLE after mem_ready; the next fetch 20 is serviced normally.
- Load and fetch requested continuously, zero-wait memory, MAX_LOAD_STREAK=4: grant order is L,L,L,L,F,L,L,L,L,F; streak returns to 0 after each F.
- Load writes 0xE3A00014 at 0, then fetch 0 with a memory model: fetch_inst = 0xE3A00014; load_ack precedes fetch_valid.
- rst asserted during FETCH wait state with mem_ready arriving 1 cycle later: no fetch_valid, mem_req low after reset, all outputs at reset values.
- Flush coincident with mem_ready: fetch_valid stays 0, state is IDLE the next cycle.
